// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizes for the countdown timer controller.
package countdown_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        PAUSED,
        DONE
    } tmr_state_e;

    typedef enum logic {
        ONE_SHOT,
        AUTO_RELOAD
    } tmr_mode_e;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_PRESC_W = 8;

endpackage

// File: rtl/countdown_timer_ctrl_counter.sv
// Loadable synchronous down counter; load takes precedence over decrement.
module sync_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown/watchdog timer sequencer: config load, start/stop/clear, one-shot or auto-reload, expire pulse and sticky irq.
// Optional tick prescaler is enabled by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer_ctrl
    import countdown_timer_pkg::*;
#(
`ifdef COUNTDOWN_PRESCALE_EN
    parameter int PRESC_W = DEFAULT_PRESC_W,
`endif
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_load_val,
    input  logic               cfg_autoload,
`ifdef COUNTDOWN_PRESCALE_EN
    input  logic [PRESC_W-1:0] cfg_presc,
`endif
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               irq_ack,
    output logic [WIDTH-1:0]   count_o,
    output logic               busy,
    output logic               expire_pulse,
    output logic               irq
);

    tmr_state_e       state;
    tmr_state_e       state_nxt;
    tmr_mode_e        mode;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cfg_fire;
    logic             tick;
    logic             expire;

    assign cfg_ready = (state != RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign busy      = (state == RUN);
    assign count_o   = count;

    sync_down_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .q        (count)
    );

    // clear beats config, config beats start; stop beats the tick inside RUN.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        expire       = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_load  = 1'b1;
        end else if (cfg_fire) begin
            state_nxt    = ARMED;
            cnt_load     = 1'b1;
            cnt_load_val = cfg_load_val;
        end else begin
            unique case (state)
                ARMED, PAUSED: begin
                    if (start) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSED;
                    end else if (tick) begin
                        if (count <= WIDTH'(1)) begin
                            expire   = 1'b1;
                            cnt_load = 1'b1;
                            if (mode == AUTO_RELOAD) begin
                                cnt_load_val = reload;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= ONE_SHOT;
            reload       <= '0;
            expire_pulse <= 1'b0;
            irq          <= 1'b0;
        end else begin
            state        <= state_nxt;
            expire_pulse <= expire;
            if (cfg_fire && !clear) begin
                reload <= cfg_load_val;
                mode   <= tmr_mode_e'(cfg_autoload);
            end
            // A fresh expiry must survive a simultaneous acknowledge.
            if (expire) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef COUNTDOWN_PRESCALE_EN
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_reload;

    // Prescaler restarts a full period on every RUN entry and freezes outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            presc_reload <= '0;
        end else if (clear) begin
            presc_cnt <= presc_cnt;
        end else if (cfg_fire) begin
            presc_cnt    <= cfg_presc;
            presc_reload <= cfg_presc;
        end else if (state != RUN && state_nxt == RUN) begin
            presc_cnt <= presc_reload;
        end else if (state == RUN && !stop) begin
            presc_cnt <= (presc_cnt == '0) ? presc_reload : presc_cnt - PRESC_W'(1);
        end
    end

    assign tick = (state == RUN) && (presc_cnt == '0);
`else
    assign tick = (state == RUN);
`endif

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl with hand-computed expectations.
module tb_countdown_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_load_val;
    logic        cfg_autoload;
`ifdef COUNTDOWN_PRESCALE_EN
    logic [7:0]  cfg_presc;
`endif
    logic        start;
    logic        stop;
    logic        clear;
    logic        irq_ack;
    logic [31:0] count_o;
    logic        busy;
    logic        expire_pulse;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    countdown_timer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_load_val (cfg_load_val),
        .cfg_autoload (cfg_autoload),
`ifdef COUNTDOWN_PRESCALE_EN
        .cfg_presc    (cfg_presc),
`endif
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .irq_ack      (irq_ack),
        .count_o      (count_o),
        .busy         (busy),
        .expire_pulse (expire_pulse),
        .irq          (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One cycle of the given control inputs, then return to idle inputs.
    task automatic applyStimulus(input logic cv, input logic [31:0] val, input logic al,
                                 input logic st, input logic sp, input logic cl, input logic ack);
        cfg_valid    = cv;
        cfg_load_val = val;
        cfg_autoload = al;
        start        = st;
        stop         = sp;
        clear        = cl;
        irq_ack      = ack;
        step(1);
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic checkState(input string tag, input logic [31:0] c, input logic b,
                              input logic p, input logic i);
        checkOutput({tag, ".count"}, count_o, c);
        checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
        checkOutput({tag, ".pulse"}, 32'(expire_pulse), 32'(p));
        checkOutput({tag, ".irq"}, 32'(irq), 32'(i));
    endtask

    initial begin
        logic [31:0] exp_cnt1 [3] = '{32'd2, 32'd1, 32'd0};
        logic        exp_pls1 [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exp_cnt2 [7] = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1};
        logic        exp_pls2 [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; cfg_valid = 1'b0; cfg_load_val = '0; cfg_autoload = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; irq_ack = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
        cfg_presc = '0;
`endif
        step(2);
        rst = 1'b0;
        checkState("reset", 0, 0, 0, 0);
        checkOutput("reset.ready", 32'(cfg_ready), 1);

        // One-shot load 3
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        checkState("os.armed", 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("os.run", 3, 1, 0, 0);
        checkOutput("os.ready_run", 32'(cfg_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkOutput($sformatf("os.cnt%0d", i), count_o, exp_cnt1[i]);
            checkOutput($sformatf("os.pls%0d", i), 32'(expire_pulse), 32'(exp_pls1[i]));
        end
        checkState("os.done", 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("os.start_in_done", 0, 0, 0, 1);

        // Auto-reload load 2, then clear mid-RUN
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("ack.irq", 32'(irq), 0);
        applyStimulus(1, 2, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("ar.run", 2, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            checkOutput($sformatf("ar.cnt%0d", i), count_o, exp_cnt2[i]);
            checkOutput($sformatf("ar.pls%0d", i), 32'(expire_pulse), 32'(exp_pls2[i]));
            checkOutput($sformatf("ar.busy%0d", i), 32'(busy), 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkState("ar.clear", 0, 0, 0, 1);

        // Pause at 3 and resume
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step(2);
        checkOutput("pause.pre", count_o, 3);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkState("pause.hold", 3, 0, 0, 0);
        step(2);
        checkState("pause.hold2", 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("pause.resume", 3, 1, 0, 0);
        step(1);
        checkOutput("pause.r2", count_o, 2);
        step(1);
        checkOutput("pause.r1", count_o, 1);
        step(1);
        checkState("pause.exp", 0, 0, 1, 1);

        // Stop on the final tick wins over expiry
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step(1);
        checkOutput("lastStop.pre", count_o, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkState("lastStop", 1, 0, 0, 0);
        step(1);
        checkOutput("lastStop.nopulse", 32'(expire_pulse), 0);

        // Expiry and irq_ack in the same cycle
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("ackRace.run", 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkState("ackRace.same", 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkState("ackRace.next", 0, 0, 0, 0);

        // Config during RUN refused; reset mid-RUN
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step(1);
        checkState("cfgRun.exp", 1, 1, 1, 1);
        cfg_valid = 1'b1;
        cfg_load_val = 9;
        #1;
        checkOutput("cfgRun.ready", 32'(cfg_ready), 0);
        step(1);
        cfg_valid = 1'b0;
        checkState("cfgRun.noload", 1, 1, 1, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkState("rstRun", 0, 0, 0, 0);
        checkOutput("rstRun.ready", 32'(cfg_ready), 1);

        // Load 0 expires on the first tick
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkState("zero.run", 0, 1, 0, 0);
        step(1);
        checkState("zero.exp", 0, 0, 1, 1);

        // Same-cycle config and start: config taken, start ignored
        applyStimulus(1, 2, 0, 1, 0, 0, 0);
        checkState("cfgStart", 2, 0, 1 - 1, 1);
        step(1);
        checkOutput("cfgStart.idle", 32'(busy), 0);

`ifdef COUNTDOWN_PRESCALE_EN
        cfg_presc = 8'd2;
        applyStimulus(1, 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step(2);
        checkOutput("presc.c2", count_o, 2);
        step(1);
        checkOutput("presc.c1", count_o, 1);
        step(2);
        checkOutput("presc.c1b", count_o, 1);
        step(1);
        checkState("presc.exp", 0, 0, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
